// File: rtl/sram_rw_ctrl_pkg.sv
// sram_ctrl_pkg: FSM states, supply levels and logic-to-real mapping for the SRAM controller.
// VFY_PULSE/VFY_RECOV exist only when SRAM_RW_CTRL_VERIFY_EN is defined.
package sram_ctrl_pkg;
  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;
  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_PULSE, RD_PULSE, RECOV, RESP
`ifdef SRAM_RW_CTRL_VERIFY_EN
    , VFY_PULSE, VFY_RECOV
`endif
  } state_t;
  function automatic real to_level(input logic b);
    return b ? VDD : VSS;
  endfunction
  function automatic logic is_rd(input state_t s);
`ifdef SRAM_RW_CTRL_VERIFY_EN
    return s == RD_PULSE || s == VFY_PULSE;
`else
    return s == RD_PULSE;
`endif
  endfunction
  function automatic logic is_gap(input state_t s);
`ifdef SRAM_RW_CTRL_VERIFY_EN
    return s == RECOV || s == VFY_RECOV;
`else
    return s == RECOV;
`endif
  endfunction
endpackage

// File: rtl/sram_rw_ctrl_level_drv.sv
// sram_level_drv: maps an N-bit logic vector onto VDD/VSS real levels, one element per bit.
module sram_level_drv
  import sram_ctrl_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [N-1:0] i_bits,
  output real          o_lvl [N]
);
  for (genvar i = 0; i < N; i++) begin : g_lvl
    assign o_lvl[i] = to_level(i_bits[i]);
  end
endmodule

// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl: one-request-at-a-time SRAM read/write sequencer with timed wordline pulses.
// Define SRAM_RW_CTRL_VERIFY_EN to add a read-back verify after every write.
module sram_rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ROWS    = 1,
  parameter int COLS    = 1,
  parameter int WR_CYC  = 10,
  parameter int RD_CYC  = 10,
  parameter int GAP_CYC = 10,
  parameter int AW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  input  logic [COLS-1:0] sa_out,
  output real             row_wr_real [ROWS],
  output real             row_rd_real [ROWS],
  output real             bl_wr_real  [COLS],
  output real             blb_wr_real [COLS]
);
  localparam int MAX_WR_RD = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
  localparam int MAXC      = (MAX_WR_RD > GAP_CYC) ? MAX_WR_RD : GAP_CYC;
  localparam int CW        = $clog2(MAXC + 1);
  localparam logic [AW:0] LIM = (AW + 1)'(ROWS);
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_load;
  logic            r_we, r_err;
  logic [AW-1:0]   r_addr;
  logic [COLS-1:0] r_wdata, r_rdata;
  logic            w_acc, w_oor, w_done, w_bl_en;
  logic [ROWS-1:0] w_sel, w_row_wr, w_row_rd;
  logic [COLS-1:0] w_bl, w_blb;
  assign w_acc  = req_valid && r_state == IDLE;
  assign w_oor  = {1'b0, req_addr} >= LIM;
  assign w_done = r_cnt == '0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (req_valid) w_next = w_oor ? RESP : req_we ? WR_SETUP : RD_PULSE;
      WR_SETUP:  w_next = WR_PULSE;
      WR_PULSE:  if (w_done) w_next = RECOV;
      RD_PULSE:  if (w_done) w_next = RECOV;
`ifdef SRAM_RW_CTRL_VERIFY_EN
      RECOV:     if (w_done) w_next = r_we ? VFY_PULSE : RESP;
      VFY_PULSE: if (w_done) w_next = VFY_RECOV;
      VFY_RECOV: if (w_done) w_next = RESP;
`else
      RECOV:     if (w_done) w_next = RESP;
`endif
      RESP:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  // counter reloads with length-1 on every state entry, so a state lasts until it reaches zero
  assign w_load = w_next == WR_PULSE ? CW'(WR_CYC - 1) :
                  is_rd(w_next)      ? CW'(RD_CYC - 1) :
                  is_gap(w_next)     ? CW'(GAP_CYC - 1) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? w_load : r_cnt - 1'b1;
      if (w_acc) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_oor;
        r_rdata <= '0;
      end
      if (r_state == RD_PULSE && w_done) r_rdata <= sa_out;
`ifdef SRAM_RW_CTRL_VERIFY_EN
      if (r_state == VFY_PULSE && w_done) r_err <= sa_out != r_wdata;
`endif
    end
  end
  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign rsp_rdata = rsp_valid ? r_rdata : '0;
  assign rsp_err   = rsp_valid && r_err;
  assign w_sel     = ROWS'(1) << r_addr;
  assign w_row_wr  = r_state == WR_PULSE ? w_sel : '0;
  assign w_row_rd  = is_rd(r_state) ? w_sel : '0;
  assign w_bl_en   = r_state == WR_SETUP || r_state == WR_PULSE;
  assign w_bl      = w_bl_en ? r_wdata : '0;
  assign w_blb     = w_bl_en ? ~r_wdata : '0;
  sram_level_drv #(.N(ROWS)) u_row_wr (.i_bits(w_row_wr), .o_lvl(row_wr_real));
  sram_level_drv #(.N(ROWS)) u_row_rd (.i_bits(w_row_rd), .o_lvl(row_rd_real));
  sram_level_drv #(.N(COLS)) u_bl     (.i_bits(w_bl),     .o_lvl(bl_wr_real));
  sram_level_drv #(.N(COLS)) u_blb    (.i_bits(w_blb),    .o_lvl(blb_wr_real));
endmodule

// File: tb/tb_sram_rw_ctrl.sv
// tb_sram_rw_ctrl: directed bench for sram_rw_ctrl with a behavioural cell-array model.
// Honours SRAM_RW_CTRL_VERIFY_EN for write latency and verify-error cases.
module tb_sram_rw_ctrl;
  import sram_ctrl_pkg::*;
  localparam int ROWS = 4, COLS = 2, AW = 3;
`ifdef SRAM_RW_CTRL_VERIFY_EN
  localparam int WLAT = 42, WRD = 10;
`else
  localparam int WLAT = 22, WRD = 0;
`endif
  logic clk, rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_err, force0;
  logic [AW-1:0] req_addr;
  logic [COLS-1:0] req_wdata, rsp_rdata, sa_out;
  real row_wr_real [ROWS], row_rd_real [ROWS], bl_wr_real [COLS], blb_wr_real [COLS];
  logic [COLS-1:0] mem [ROWS];
  sram_rw_ctrl #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .sa_out(sa_out),
    .row_wr_real(row_wr_real), .row_rd_real(row_rd_real),
    .bl_wr_real(bl_wr_real), .blb_wr_real(blb_wr_real)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk)
    for (int r = 0; r < ROWS; r++)
      if (row_wr_real[r] > VTH)
        for (int c = 0; c < COLS; c++) mem[r][c] <= bl_wr_real[c] > VTH;
  always_comb begin
    sa_out = '0;
    for (int r = 0; r < ROWS; r++) if (row_rd_real[r] > VTH) sa_out = mem[r];
    if (force0) sa_out = '0;
  end
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input real got, input real exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0.2f expected %0.2f", tag, got, exp);
  endtask
  int rsp_at, n_rsp, wr_n, wr_first, rd_n, rd_first, wl_tot, bad, rdy_after;
  logic [COLS-1:0] rd_v;
  logic er_v;
  real bl_t1 [COLS], blb_t1 [COLS];
  task automatic run(input logic we, input logic [AW-1:0] addr, input logic [COLS-1:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    rsp_at = -1; n_rsp = 0; wr_n = 0; wr_first = -1; rd_n = 0; rd_first = -1;
    wl_tot = 0; bad = 0; rdy_after = 0; rd_v = '0; er_v = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      int hi;
      @(negedge clk);
      if (k == 1) begin
        req_we = ~we; req_addr = '0; req_wdata = ~wd;
        for (int c = 0; c < COLS; c++) begin bl_t1[c] = bl_wr_real[c]; blb_t1[c] = blb_wr_real[c]; end
      end
      hi = 0;
      for (int r = 0; r < ROWS; r++) begin
        if (row_wr_real[r] > VTH) begin
          hi++;
          if (r == int'(addr)) begin wr_n++; if (wr_first < 0) wr_first = k; end
        end
        if (row_rd_real[r] > VTH) begin
          hi++;
          if (r == int'(addr)) begin rd_n++; if (rd_first < 0) rd_first = k; end
        end
      end
      wl_tot += hi;
      if (hi > 1) bad++;
      for (int c = 0; c < COLS; c++) if (bl_wr_real[c] > VTH && blb_wr_real[c] > VTH) bad++;
      if (rsp_at > 0 && k == rsp_at + 1) begin
        rdy_after = int'(req_ready);
        req_valid = 1'b0;
        break;
      end
      if (req_ready) bad++;
      if (rsp_valid) begin
        if (rsp_at < 0) begin rsp_at = k; rd_v = rsp_rdata; er_v = rsp_err; end
        else n_rsp++;
      end
    end
    req_valid = 1'b0;
  endtask
  task automatic txn(input string t, input logic we, input logic [AW-1:0] addr,
                     input logic [COLS-1:0] wd, input int lat, input logic [COLS-1:0] xrd, input logic xer);
    run(we, addr, wd);
    chk({t, " latency"}, rsp_at, lat);
    chk({t, " rdata"}, rd_v, xrd);
    chk({t, " err"}, er_v, xer);
    chk({t, " extra_rsp"}, n_rsp, 0);
    chk({t, " ready_after"}, rdy_after, 1);
    chk({t, " invariants"}, bad, 0);
    chk({t, " other_rows"}, wl_tot, wr_n + rd_n);
    if (int'(addr) >= ROWS) chk({t, " no_wordline"}, wl_tot, 0);
    else if (we) begin
      chk({t, " wr_cycles"}, wr_n, 10);
      chk({t, " wr_first"}, wr_first, 2);
      chk({t, " vfy_rd_cycles"}, rd_n, WRD);
      for (int c = 0; c < COLS; c++) begin
        chk({t, " bl_t1"}, bl_t1[c], wd[c] ? 1.5 : 0.0);
        chk({t, " blb_t1"}, blb_t1[c], wd[c] ? 0.0 : 1.5);
      end
    end else begin
      chk({t, " rd_cycles"}, rd_n, 10);
      chk({t, " rd_first"}, rd_first, 1);
      chk({t, " rd_no_wr"}, wr_n, 0);
    end
  endtask
  real sum;
  int cnt;
  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; force0 = 1'b0;
    #3 rst_n = 1'b0;
    #20;
    sum = 0.0;
    for (int r = 0; r < ROWS; r++) sum += row_wr_real[r] + row_rd_real[r];
    for (int c = 0; c < COLS; c++) sum += bl_wr_real[c] + blb_wr_real[c];
    chk("rst levels", sum, 0.0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_err", rsp_err, 0);
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      for (int r = 0; r < ROWS; r++) if (row_wr_real[r] > VTH || row_rd_real[r] > VTH) cnt++;
    end
    chk("idle no wordline", cnt, 0);
    chk("idle ready", req_ready, 1);
    txn("wr01", 1'b1, 3'd2, 2'b01, WLAT, 2'b00, 1'b0);
    txn("rd01", 1'b0, 3'd2, 2'b00, 21, 2'b01, 1'b0);
    txn("wr10", 1'b1, 3'd2, 2'b10, WLAT, 2'b00, 1'b0);
    txn("rd10", 1'b0, 3'd2, 2'b00, 21, 2'b10, 1'b0);
    txn("wr11", 1'b1, 3'd1, 2'b11, WLAT, 2'b00, 1'b0);
    txn("rd11", 1'b0, 3'd1, 2'b00, 21, 2'b11, 1'b0);
    txn("wr00", 1'b1, 3'd1, 2'b00, WLAT, 2'b00, 1'b0);
    txn("rd00", 1'b0, 3'd1, 2'b00, 21, 2'b00, 1'b0);
    txn("rd_row2", 1'b0, 3'd2, 2'b00, 21, 2'b10, 1'b0);
    txn("oor5", 1'b0, 3'd5, 2'b00, 1, 2'b00, 1'b1);
    txn("oor4", 1'b1, 3'd4, 2'b11, 1, 2'b00, 1'b1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd3; req_wdata = 2'b11;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort pulse high", row_wr_real[3], 1.5);
    rst_n = 1'b0;
    #1;
    chk("abort row_wr drop", row_wr_real[3], 0.0);
    chk("abort bl drop", bl_wr_real[0] + bl_wr_real[1], 0.0);
    chk("abort rsp_valid", rsp_valid, 0);
    chk("abort ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
      for (int r = 0; r < ROWS; r++) if (row_wr_real[r] > VTH || row_rd_real[r] > VTH) cnt++;
    end
    chk("abort no activity", cnt, 0);
    txn("post_rst_wr", 1'b1, 3'd3, 2'b01, WLAT, 2'b00, 1'b0);
    txn("post_rst_rd", 1'b0, 3'd3, 2'b00, 21, 2'b01, 1'b0);
`ifdef SRAM_RW_CTRL_VERIFY_EN
    force0 = 1'b1;
    txn("vfy_bad", 1'b1, 3'd0, 2'b11, 42, 2'b00, 1'b1);
    force0 = 1'b0;
    txn("vfy_ok", 1'b1, 3'd0, 2'b11, 42, 2'b00, 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_rw_ctrl.md
# sram_rw_ctrl

Clocked read/write sequencer for the SRAM cell array and sense amplifier. Accepts one request at a time over a valid/ready handshake and drives the write wordlines, read wordlines and write bitline pairs with fixed-length pulses and recovery gaps. It samples the digitized sense-amp output and returns a one-cycle response. It sits between the digital test/host logic and the real-valued array model.

## Interface
- ROWS, 1, number of array rows
- COLS, 1, data width; one bit per column
- WR_CYC, 10, write wordline pulse length in cycles (≥1)
- RD_CYC, 10, read wordline pulse length in cycles (≥1)
- GAP_CYC, 10, recovery cycles after every pulse (≥1)
- AW, $clog2(ROWS) with a minimum of 1, address width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  row index
- req_wdata  in  COLS  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  COLS  read data; 0 for writes
- rsp_err  out  1  address out of range, or verify mismatch
- sa_out  in  COLS  sense-amp output, digitized (preout > VTH)
- row_wr_real  out  real[ROWS]  write wordlines, VDD/VSS
- row_rd_real  out  real[ROWS]  read wordlines, VDD/VSS
- bl_wr_real, blb_wr_real  out  real[COLS]  write bitline pair, VDD/VSS

## Operation
- States: IDLE, WR_SETUP, WR_PULSE, RD_PULSE, RECOV, RESP.
  - VFY states exist only with the configuration macro.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/wdata.
  - addr ≥ ROWS → RESP with rsp_err=1; no wordline asserted.
  - Otherwise, write → WR_SETUP and read → RD_PULSE.
- WR_SETUP (1 cycle):
  - bl=wdata, blb=~wdata; all wordlines low.
- WR_PULSE (WR_CYC cycles):
  - row_wr[addr]=VDD; bitlines held.
- RD_PULSE (RD_CYC cycles):
  - row_rd[addr]=VDD; write bitlines both VSS.
  - sa_out is captured into the read register on the last pulse cycle.
- RECOV (GAP_CYC cycles):
  - All wordlines VSS; both write bitlines VSS.
- RESP (1 cycle):
  - rsp_valid=1 with rdata/err; next state IDLE.
- Invariants:
  - At most one wordline is high across row_wr and row_rd combined.
  - Bitlines change only while every row_wr is low.
  - bl and blb are never both VDD.
- A single down-counter of width $clog2(max(WR_CYC,RD_CYC,GAP_CYC)+1) times every state and reloads on each state entry.
- Logic-to-real mapping: 1→VDD=1.5, 0→VSS=0.0.

## Timing
- Accept cycle T (req_valid & req_ready). req_ready is low from T+1 until the RESP cycle; it is high again in the cycle after RESP.
- Write: WR_SETUP at T+1, wordline T+2..T+1+WR_CYC, rsp_valid at T+2+WR_CYC+GAP_CYC.
  - With defaults, rsp_valid is at T+22.
- Read: wordline T+1..T+RD_CYC, sample at T+RD_CYC, rsp_valid at T+1+RD_CYC+GAP_CYC.
  - With defaults, rsp_valid is at T+21.
- Out-of-range request: rsp_valid at T+1 with err=1.
- req_* inputs are ignored while req_ready=0. Back-to-back requests are accepted in the cycle after RESP.
- Reset: applies asynchronously and immediately.
  - All wordlines and bitlines go to VSS.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - State is IDLE, req_ready=1 once rst_n=1.
- Reset mid-operation aborts the pulse at once and produces no response.

## Configuration
- SRAM_RW_CTRL_VERIFY_EN defined:
  - After a write's RECOV, the controller enters VFY_PULSE (RD_CYC cycles, row_rd[addr]) and then VFY_RECOV (GAP_CYC cycles).
  - It compares the sampled sa_out with wdata; rsp_err=1 on mismatch.
  - Write latency grows by RD_CYC+GAP_CYC (T+42 with defaults).
- SRAM_RW_CTRL_VERIFY_EN not defined:
  - No verify states. rsp_err is set only for out-of-range addresses.

## Structure
- Package sram_ctrl_pkg:
  - State enum.
  - VDD=1.5, VSS=0.0, VTH=0.8 constants.
  - to_level(logic)→real function.
- Sub-module sram_level_drv (parameter N): converts an N-bit logic vector to a real[N] array. It is instantiated once per output group (row_wr, row_rd, bl, blb).

## Test plan
- Reset with rst_n=0:
  - All real outputs are 0.0, rsp_valid=0, req_ready=1.
  - After release, no wordline rises without a request.
- ROWS=1, COLS=1, write 1 to addr 0:
  - bl=1.5 and blb=0.0 at T+1.
  - row_wr[0]=1.5 for exactly 10 cycles.
  - rsp_valid only at T+22, err=0.
- Read after write 1:
  - row_rd[0] high for 10 cycles, rsp_rdata=1 at T+21.
  - Then write 0 followed by read returns rdata=0.
- ROWS=4, request addr 5:
  - rsp_err=1 at T+1; every wordline stays 0.0.
- Assert rst_n low 4 cycles into WR_PULSE:
  - row_wr drops in the same timestep; no rsp_valid.
  - The next request completes normally.
- With SRAM_RW_CTRL_VERIFY_EN defined, force sa_out=0 during verify of a write 1:
  - rsp_err=1 at T+42.
  - With sa_out correct, rsp_err=0.
